// File: rtl/ifu_prefetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_prefetch_buf                                             |
// | Description : Instruction prefetch buffer between the instruction bus and |
// |               the IF/ID register. Issues sequential word fetches, queues  |
// |               {pc, instr} pairs and hands them downstream on a            |
// |               valid/ready handshake. A redirect flushes the queue and     |
// |               discards responses that are still in flight.                |
// | Options     : PREFETCH_BYPASS_EN - when defined, a response arriving at   |
// |               an empty, clean buffer is presented combinationally         |
// |               (0-cycle latency) instead of one cycle later.               |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module ifu_prefetch_buf #(
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  output logic                  ibus_req_o,
  output logic [ADDR_WIDTH-1:0] ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ibus_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned           PTR_W     = $clog2(DEPTH);
  localparam int unsigned           CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned           RSV_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0]      C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [RSV_W-1:0]      C_RSV_MAX = RSV_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(4);

  // Queue storage (no reset needed: outputs are forced to zero while empty)
  logic [DATA_WIDTH-1:0] mem_instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_instr_d [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_d    [DEPTH];

  // Control state
  logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]      count_q,       count_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      drop_cnt_q,    drop_cnt_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q,     resp_pc_d;
  logic                  issue_en_q,    issue_en_d;

  // Combinational decode
  logic                  fifo_empty;
  logic [RSV_W-1:0]      reserved;
  logic                  gnt_fire;
  logic                  resp_drop;
  logic                  resp_keep;
  logic                  bypass_hit;
  logic                  bypass_take;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] flush_pc_aligned;
  logic                  unused_flush_lsbs;

  // Redirect target is forced to a word boundary; the low bits are ignored.
  assign flush_pc_aligned  = {flush_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_flush_lsbs = ^flush_pc_i[1:0];

  assign fifo_empty = (count_q == '0);

  // Slots already spoken for: queued entries plus responses that will be kept.
  // drop_cnt never exceeds outstanding, so this cannot underflow.
  assign reserved = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};

  assign gnt_fire  = ibus_req_o & ibus_gnt_i;
  assign resp_drop = ibus_rvalid_i & (drop_cnt_q != '0);
  assign resp_keep = ibus_rvalid_i & (drop_cnt_q == '0) & ~flush_i;

`ifdef PREFETCH_BYPASS_EN
  // A clean response arriving at an empty buffer goes straight to the output.
  assign bypass_hit = fifo_empty & (drop_cnt_q == '0) & ~flush_i & ibus_rvalid_i;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit & instr_ready_i;
  assign push        = resp_keep & ~bypass_take;
  assign pop         = ~fifo_empty & instr_ready_i & ~flush_i;

  // Request issue: stop when every slot is reserved or the bus is saturated.
  always_comb begin
    ibus_req_o  = 1'b0;
    ibus_addr_o = fetch_pc_q;
    if (issue_en_q && !flush_i && (reserved < C_RSV_MAX) && (outstanding_q < C_DEPTH)) begin
      ibus_req_o = 1'b1;
    end
  end

  // Output mux: head entry, the bypassed response, or zeros when empty.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = '0;
    pc_o          = '0;
    if (!fifo_empty) begin
      instr_valid_o = 1'b1;
      instr_o       = mem_instr_q[rd_ptr_q];
      pc_o          = mem_pc_q[rd_ptr_q];
    end else if (bypass_hit) begin
      instr_valid_o = 1'b1;
      instr_o       = ibus_rdata_i;
      pc_o          = resp_pc_q;
    end
  end

  // Queue write: capture the kept response at the write pointer.
  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    if (push) begin
      mem_instr_d[wr_ptr_q] = ibus_rdata_i;
      mem_pc_d[wr_ptr_q]    = resp_pc_q;
    end
  end

  // Next-state: a flush overrides grants, pushes and pops in the same cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    issue_en_d    = 1'b1;
    if (flush_i) begin
      // No request issues during a flush, so only a response can retire here.
      fetch_pc_d    = flush_pc_aligned;
      resp_pc_d     = flush_pc_aligned;
      outstanding_d = outstanding_q - CNT_W'(ibus_rvalid_i);
      drop_cnt_d    = outstanding_q - CNT_W'(ibus_rvalid_i);
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + C_PC_STEP;
      end
      outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(ibus_rvalid_i);
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + C_PC_STEP;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      issue_en_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      issue_en_q    <= issue_en_d;
    end
  end

  // Queue storage registers.
  always_ff @(posedge clk) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

  // The reservation accounting must keep a push away from a full queue.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == C_DEPTH)));

  // Every response must belong to a granted request.
  assert property (@(posedge clk) disable iff (!rst_n) !(ibus_rvalid_i && (outstanding_q == '0)));

endmodule
`default_nettype wire
